// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: FSM state type, default
// filter length and a helper that maps a state onto the debounced level.
package key_pkg;

  // 20 ms of stable input at a 50 MHz system clock.
  localparam int KEY_CNT_MAX_DEFAULT = 1_000_000;

  // Depth of the input synchronizer in front of the filter.
  localparam int KEY_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    PRESS_FILTER   = 2'd1,
    PRESSED        = 2'd2,
    RELEASE_FILTER = 2'd3
  } key_state_e;

  // Debounced (active-low) key level implied by a filter state: the key
  // counts as pressed from the moment a press is confirmed until the
  // matching release is confirmed.
  function automatic logic key_level(input key_state_e s);
    return !((s == PRESSED) || (s == RELEASE_FILTER));
  endfunction

endpackage

// File: rtl/key_sync.sv
// Multi-flop synchronizer for the raw asynchronous key input. All stages
// reset to the released level so no spurious press appears out of reset.
module key_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/key_filter.sv
// Mechanical key debouncer. The synchronized key level must hold for
// CNT_MAX consecutive cycles before a press or release is accepted.
// key_out is the debounced active-low level; key_flag strobes for one
// cycle on each confirmed press. Both outputs are registered, so they
// trail the state change that confirms a press/release by one cycle.
module key_filter
  import key_pkg::*;
#(
  parameter int CNT_MAX = KEY_CNT_MAX_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_out,
  output logic key_flag
);

  localparam int            CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          w_key_s;
  key_state_e    r_state;
  key_state_e    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_key_out;
  logic          r_key_flag;
  logic          w_key_out_next;
  logic          w_key_flag_next;

  key_sync #(
    .STAGES  (KEY_SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk (sys_clk),
    .i_rst (sys_rst),
    .i_d   (key_in),
    .o_q   (w_key_s)
  );

  // State and stability counter registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and counter logic: the count holds the number of
  // consecutive samples seen at the candidate level, and any sample at
  // the old level sends the filter back without changing the output.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (!w_key_s) begin
          w_state_next = PRESS_FILTER;
          w_cnt_next   = CNT_ONE;
        end else begin
          w_cnt_next   = '0;
        end
      end
      PRESS_FILTER: begin
        if (w_key_s) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = PRESSED;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (w_key_s) begin
          w_state_next = RELEASE_FILTER;
          w_cnt_next   = CNT_ONE;
        end else begin
          w_cnt_next   = '0;
        end
      end
      RELEASE_FILTER: begin
        if (!w_key_s) begin
          w_state_next = PRESSED;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output decode: key_out follows the state's debounced level. The flag
  // fires in the first PRESSED cycle after a confirmed press, recognised
  // by r_key_out still showing released; re-entering PRESSED from
  // RELEASE_FILTER finds r_key_out already low, so bounce on release
  // never produces a second strobe.
  always_comb begin
    w_key_out_next  = key_level(r_state);
    w_key_flag_next = (r_state == PRESSED) && r_key_out;
  end

  // Output registers, forced to the released/idle values in reset so a
  // reset mid-filter or while pressed never leaks a strobe.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_key_out  <= 1'b1;
      r_key_flag <= 1'b0;
    end else begin
      r_key_out  <= w_key_out_next;
      r_key_flag <= w_key_flag_next;
    end
  end

  assign key_out  = r_key_out;
  assign key_flag = r_key_flag;

  // key_flag is a single-cycle strobe.
  a_flag_single : assert property (
    @(posedge sys_clk) disable iff (sys_rst) key_flag |=> !key_flag
  );

  // A strobe is only ever issued together with a pressed level.
  a_flag_pressed : assert property (
    @(posedge sys_clk) disable iff (sys_rst) key_flag |-> !key_out
  );

endmodule
